// File: rtl/ip_ws2812_chain.sv
// WS2812 daisy-chain driver: per-LED GRB storage, whole-chain frame on update.
// Optional `define WS2812_BRIGHTNESS_EN adds a global brightness scaler.
module ip_ws2812_chain #(
    parameter int LED_COUNT  = 8,
    parameter int IDX_W      = 3,
    parameter int T0H_CYC    = 17,
    parameter int T1H_CYC    = 34,
    parameter int TBIT_CYC   = 54,
    parameter int TRESET_CYC = 2600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [IDX_W-1:0] index,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic             update,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    output logic             busy,
    output logic             ws2812_led
);

    localparam int CMAX = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]    HI1  = CW'(T1H_CYC - 1);
    localparam logic [CW-1:0]    HI0  = CW'(T0H_CYC - 1);
    localparam logic [CW-1:0]    BEND = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0]    LEND = CW'(TRESET_CYC);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(LED_COUNT - 1);
    localparam logic [IDX_W:0]   NLED = (IDX_W + 1)'(LED_COUNT);

    typedef enum logic [2:0] {IDLE, LOAD, BIT_H, BIT_L, LATCH} state_t;

    state_t           state;
    logic [23:0]      mem [LED_COUNT];
    logic [23:0]      sreg;
    logic [23:0]      raw;
    logic [23:0]      fetch;
    logic [IDX_W-1:0] led_idx;
    logic [IDX_W-1:0] fetch_idx;
    logic [CW-1:0]    cyc;
    logic [CW-1:0]    hi_end;
    logic [4:0]       bitcnt;
    logic             pending;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (wr && ({1'b0, index} < NLED))
            mem[index] <= {green, red, blue};
    end

    // Next LED is read at the load edge itself, so late writes still make it.
    always_comb begin
        fetch_idx = (state == LOAD) ? '0 : led_idx + 1'b1;
        raw       = mem[fetch_idx];
`ifdef WS2812_BRIGHTNESS_EN
        fetch = {scale(raw[23:16], brightness),
                 scale(raw[15:8], brightness),
                 scale(raw[7:0], brightness)};
`else
        fetch = raw;
`endif
        hi_end = sreg[23] ? HI1 : HI0;
    end

    // The line lags the state by one cycle; LATCH runs one extra state
    // cycle so the line still sees exactly TRESET_CYC low clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            busy       <= 1'b0;
            ws2812_led <= 1'b0;
            cyc        <= '0;
            bitcnt     <= '0;
            led_idx    <= '0;
            sreg       <= '0;
        end else begin
            ws2812_led <= (state == BIT_H);
            if (update && state != IDLE)
                pending <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (update) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    sreg    <= fetch;
                    bitcnt  <= 5'd23;
                    led_idx <= '0;
                    cyc     <= '0;
                    state   <= BIT_H;
                end
                BIT_H: begin
                    cyc <= cyc + 1'b1;
                    if (cyc == hi_end)
                        state <= BIT_L;
                end
                BIT_L: begin
                    if (cyc == BEND) begin
                        cyc   <= '0;
                        state <= BIT_H;
                        if (bitcnt == 5'd0) begin
                            if (led_idx == LAST) begin
                                state <= LATCH;
                            end else begin
                                led_idx <= led_idx + 1'b1;
                                sreg    <= fetch;
                                bitcnt  <= 5'd23;
                            end
                        end else begin
                            sreg   <= sreg << 1;
                            bitcnt <= bitcnt - 5'd1;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                LATCH: begin
                    if (cyc == LEND) begin
                        cyc     <= '0;
                        pending <= 1'b0;
                        if (pending || update) begin
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_ws2812_chain.sv
// Directed bench for ip_ws2812_chain: 2 LEDs, short bit timing.
// Line and busy are sampled every negedge into arrays and decoded afterwards.
module tb_ip_ws2812_chain;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic       update;
    logic [1:0] index;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       busy;
    logic       ws2812_led;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0] brightness = 8'hFF;
`endif

    always #5 clk = ~clk;

    ip_ws2812_chain #(
        .LED_COUNT (2),
        .IDX_W     (2),
        .T0H_CYC   (2),
        .T1H_CYC   (4),
        .TBIT_CYC  (6),
        .TRESET_CYC(10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .index     (index),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .update    (update),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .busy      (busy),
        .ws2812_led(ws2812_led)
    );

    int   tests = 0;
    int   fails = 0;
    logic s [0:699];
    logic b [0:699];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] i, input logic [23:0] grb);
        wr    = 1'b1;
        index = i;
        green = grb[23:16];
        red   = grb[15:8];
        blue  = grb[7:0];
        @(negedge clk);
        wr = 1'b0;
    endtask

    // s[k]/b[k] hold the values right after edge t+k, t = update edge.
    task automatic run_frame(input int n, input int u1, input int u2, input int u3,
                             input int wk, input logic [1:0] wi, input logic [23:0] wd);
        update = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k > 0)
                @(negedge clk);
            s[k]   = ws2812_led;
            b[k]   = busy;
            update = (k + 1 == u1) || (k + 1 == u2) || (k + 1 == u3);
            wr     = (k + 1 == wk);
            if (k + 1 == wk) begin
                index = wi;
                green = wd[23:16];
                red   = wd[15:8];
                blue  = wd[7:0];
            end
        end
        update = 1'b0;
        wr     = 1'b0;
    endtask

    function automatic int highs(input int base, input int len);
        int c = 0;
        for (int i = 0; i < len; i++)
            c += int'(s[base + i]);
        return c;
    endfunction

    function automatic int rise_at(input int start);
        for (int k = start; k < 700; k++)
            if (s[k] === 1'b1)
                return k;
        return -1;
    endfunction

    function automatic int fall_at(input int start);
        for (int k = start; k < 700; k++)
            if (b[k] !== 1'b1)
                return k;
        return -1;
    endfunction

    task automatic decode(input int base, output logic [47:0] rx, output int nbad);
        int c;
        nbad = 0;
        rx   = '0;
        for (int j = 0; j < 48; j++) begin
            c = highs(base + 6 * j, 6);
            if (!(c == 2 || c == 4) || s[base + 6 * j] !== 1'b1 || s[base + 6 * j + 5] !== 1'b0)
                nbad++;
            rx[47 - j] = (c == 4);
        end
    endtask

    initial begin
        logic [47:0] rx;
        int          nb;
        int          hi;

        reset  = 1'b1;
        wr     = 1'b0;
        update = 1'b0;
        index  = '0;
        red    = '0;
        green  = '0;
        blue   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_led", ws2812_led, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(ws2812_led) + int'(busy);
        end
        check("idle_quiet", hi, 0);

        put(2'd0, 24'h800001);
        put(2'd1, 24'hFFFFFF);
        run_frame(305, -1, -1, -1, -1, 2'd0, 24'h0);
        check("a_rise", rise_at(0), 2);
        decode(2, rx, nb);
        check("a_data", rx, 48'h800001_FFFFFF);
        check("a_shape", nb, 0);
        check("a_b23_hi", highs(2, 6), 4);
        check("a_b22_hi", highs(8, 6), 2);
        check("a_b0_hi", highs(2 + 23 * 6, 6), 4);
        check("a_latch_low", highs(290, 10), 0);
        check("a_busy_fall", fall_at(0), 300);

        put(2'd3, 24'h555555);
        run_frame(305, -1, -1, -1, -1, 2'd0, 24'h0);
        decode(2, rx, nb);
        check("b_data", rx, 48'h800001_FFFFFF);
        check("b_shape", nb, 0);

        wr    = 1'b1;
        index = 2'd0;
        green = 8'h0F;
        red   = 8'h00;
        blue  = 8'hA5;
        run_frame(305, -1, -1, -1, 50, 2'd1, 24'h123456);
        decode(2, rx, nb);
        check("c_data", rx, 48'h0F00A5_123456);
        check("c_busy_fall", fall_at(0), 300);

        run_frame(610, 50, 60, 70, -1, 2'd0, 24'h0);
        check("d_busy_fall", fall_at(0), 600);
        check("d_rise2", rise_at(290), 302);
        decode(2, rx, nb);
        check("d_data1", rx, 48'h0F00A5_123456);
        decode(302, rx, nb);
        check("d_data2", rx, 48'h0F00A5_123456);
        check("d_shape2", nb, 0);
        check("d_latch_low", highs(590, 10), 0);

        run_frame(150, 60, -1, -1, -1, 2'd0, 24'h0);
        check("e_busy_pre", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("e_rst_led", ws2812_led, 0);
        check("e_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        hi = 0;
        repeat (400) begin
            @(negedge clk);
            hi += int'(ws2812_led) + int'(busy);
        end
        check("e_quiet", hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
